mmb_burst_splitter: RTL and testbench

- Sits between mmb_arbitrator (upstream) and the slave path (mmb_reg_buffer / memory).
- Splits MemoryMapped burst transactions longer than MAXBCNT into consecutive sub-bursts of at most MAXBCNT words, with correctly advanced word addresses.
- Lets wide-bcnt masters share slaves with a narrower burst limit.
- Read data returns in order and passes straight through.

---
 rtl/mmb_pkg.sv | 11 +
 rtl/mmb_burst_splitter.sv | 141 ++++++++++++++
 tb/tb_mmb_burst_splitter.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmb_pkg.sv
// Shared types for the MemoryMapped burst path.
// Holds the burst-splitter FSM state encoding.
package mmb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StRead  = 2'd2
    } split_state_t;

endpackage

// File: rtl/mmb_burst_splitter.sv
// Splits upstream bursts longer than MAXBCNT into back-to-back downstream sub-bursts
// with advancing word addresses; read data passes straight through in order.
module mmb_burst_splitter
    import mmb_pkg::*;
#(
    parameter int unsigned AWIDTH  = 8,
    parameter int unsigned DWIDTH  = 8,
    parameter int unsigned SBWIDTH = 6,
    parameter int unsigned MBWIDTH = 4,
    parameter int unsigned MAXBCNT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [AWIDTH-1:0]  s_addr,
    input  logic [SBWIDTH-1:0] s_bcnt,
    input  logic               s_wreq,
    input  logic [DWIDTH-1:0]  s_wdat,
    input  logic               s_rreq,
    output logic [DWIDTH-1:0]  s_rdat,
    output logic               s_rval,
    output logic               s_busy,
    output logic [AWIDTH-1:0]  m_addr,
    output logic [MBWIDTH-1:0] m_bcnt,
    output logic               m_wreq,
    output logic [DWIDTH-1:0]  m_wdat,
    output logic               m_rreq,
    input  logic [DWIDTH-1:0]  m_rdat,
    input  logic               m_rval,
    input  logic               m_busy
);

    localparam logic [SBWIDTH-1:0] MaxS = SBWIDTH'(MAXBCNT);
    localparam logic [AWIDTH-1:0]  MaxA = AWIDTH'(MAXBCNT);

    split_state_t       state_q, state_d;
    logic [AWIDTH-1:0]  nxt_addr_q, nxt_addr_d;
    logic [SBWIDTH-1:0] tot_left_q, tot_left_d;
    logic [MBWIDTH-1:0] chk_left_q, chk_left_d;

    function automatic logic [MBWIDTH-1:0] len(input logic [SBWIDTH-1:0] x);
        if (x > MaxS) begin
            return MBWIDTH'(MAXBCNT);
        end
        return MBWIDTH'(x);
    endfunction

    assign s_rdat = m_rdat;
    assign s_rval = m_rval;
    assign m_wdat = s_wdat;

    always_comb begin
        state_d    = state_q;
        nxt_addr_d = nxt_addr_q;
        tot_left_d = tot_left_q;
        chk_left_d = chk_left_q;
        m_addr     = s_addr;
        m_bcnt     = len(s_bcnt);
        m_wreq     = 1'b0;
        m_rreq     = 1'b0;
        s_busy     = m_busy;

        unique case (state_q)
            StIdle: begin
                m_wreq = s_wreq;
                m_rreq = s_rreq & ~s_wreq;
                if (s_wreq) begin
                    if (!m_busy && s_bcnt > SBWIDTH'(1)) begin
                        state_d    = StWrite;
                        tot_left_d = s_bcnt - SBWIDTH'(1);
                        chk_left_d = len(s_bcnt) - MBWIDTH'(1);
                        nxt_addr_d = s_addr + AWIDTH'(len(s_bcnt));
                    end
                end else if (s_rreq && s_bcnt > MaxS) begin
                    // Upstream stays stalled until the final sub-burst is taken.
                    s_busy = 1'b1;
                    if (!m_busy) begin
                        state_d    = StRead;
                        tot_left_d = s_bcnt - MaxS;
                        nxt_addr_d = s_addr + MaxA;
                    end
                end
            end
            StWrite: begin
                m_addr = nxt_addr_q;
                m_bcnt = len(tot_left_q);
                m_wreq = s_wreq;
                if (s_wreq && !m_busy) begin
                    tot_left_d = tot_left_q - SBWIDTH'(1);
                    // chk_left of zero means this beat opens the next sub-burst.
                    if (chk_left_q == '0) begin
                        chk_left_d = len(tot_left_q) - MBWIDTH'(1);
                        nxt_addr_d = nxt_addr_q + AWIDTH'(len(tot_left_q));
                    end else begin
                        chk_left_d = chk_left_q - MBWIDTH'(1);
                    end
                    if (tot_left_q == SBWIDTH'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            StRead: begin
                m_rreq = 1'b1;
                m_addr = nxt_addr_q;
                m_bcnt = len(tot_left_q);
                s_busy = m_busy | (tot_left_q > MaxS);
                if (!m_busy) begin
                    if (tot_left_q <= MaxS) begin
                        state_d = StIdle;
                    end else begin
                        tot_left_d = tot_left_q - MaxS;
                        nxt_addr_d = nxt_addr_q + MaxA;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (!reset) begin
            m_wreq = 1'b0;
            m_rreq = 1'b0;
            s_busy = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            nxt_addr_q <= '0;
            tot_left_q <= '0;
            chk_left_q <= '0;
        end else begin
            state_q    <= state_d;
            nxt_addr_q <= nxt_addr_d;
            tot_left_q <= tot_left_d;
            chk_left_q <= chk_left_d;
        end
    end

endmodule

// File: tb/tb_mmb_burst_splitter.sv
// Bench for mmb_burst_splitter: directed bursts against a split/memory model and a
// downstream slave with optional random stalls and in-order read return.
module tb_mmb_burst_splitter;

    localparam int MAXB = 8;

    typedef struct packed {
        logic [7:0] addr;
        logic [3:0] bcnt;
        logic       wr;
    } sb_t;
    typedef sb_t sb_q_t[$];

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] s_addr = '0;
    logic [5:0] s_bcnt = '0;
    logic       s_wreq = 1'b0;
    logic [7:0] s_wdat = '0;
    logic       s_rreq = 1'b0;
    logic [7:0] s_rdat;
    logic       s_rval;
    logic       s_busy;
    logic [7:0] m_addr;
    logic [3:0] m_bcnt;
    logic       m_wreq;
    logic [7:0] m_wdat;
    logic       m_rreq;
    logic [7:0] m_rdat = '0;
    logic       m_rval = 1'b0;
    logic       m_busy = 1'b0;

    int checks = 0;
    int errors = 0;
    bit rand_busy = 1'b0;

    logic [7:0] ref_mem [256];
    logic [7:0] slv_mem [256];
    sb_q_t      exp_sb;
    logic [7:0] exp_rdat [$];
    logic [7:0] rd_pend [$];
    logic [7:0] rd_log [$];
    logic [7:0] obs_addr [$];
    int         obs_bcnt [$];
    logic [7:0] w_addr = '0;
    int         w_left = 0;
    sb_t        cur_e;

    mmb_burst_splitter #(
        .AWIDTH (8),
        .DWIDTH (8),
        .SBWIDTH(6),
        .MBWIDTH(4),
        .MAXBCNT(MAXB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .s_addr(s_addr),
        .s_bcnt(s_bcnt),
        .s_wreq(s_wreq),
        .s_wdat(s_wdat),
        .s_rreq(s_rreq),
        .s_rdat(s_rdat),
        .s_rval(s_rval),
        .s_busy(s_busy),
        .m_addr(m_addr),
        .m_bcnt(m_bcnt),
        .m_wreq(m_wreq),
        .m_wdat(m_wdat),
        .m_rreq(m_rreq),
        .m_rdat(m_rdat),
        .m_rval(m_rval),
        .m_busy(m_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference split: consecutive chunks of at most MAXB words, address wraps at 256.
    function automatic sb_q_t split(input logic [7:0] a, input int n, input bit wr);
        sb_q_t q;
        int    l;
        while (n > 0) begin
            l = (n > MAXB) ? MAXB : n;
            q.push_back('{addr: a, bcnt: 4'(l), wr: wr});
            a = a + 8'(l);
            n -= l;
        end
        return q;
    endfunction

    task automatic sb_start(input bit wr);
        obs_addr.push_back(m_addr);
        obs_bcnt.push_back(int'(m_bcnt));
        chk("sb_pending", 32'(exp_sb.size() != 0), 32'd1);
        if (exp_sb.size() != 0) begin
            cur_e = exp_sb.pop_front();
            chk("sb_addr", 32'(m_addr), 32'(cur_e.addr));
            chk("sb_bcnt", 32'(m_bcnt), 32'(cur_e.bcnt));
            chk("sb_kind", 32'(wr), 32'(cur_e.wr));
        end
    endtask

    // Compare process: checks every cycle and tracks downstream burst boundaries.
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_s_busy", 32'(s_busy), 32'd1);
            chk("rst_m_wreq", 32'(m_wreq), 32'd0);
            chk("rst_m_rreq", 32'(m_rreq), 32'd0);
            w_left = 0;
        end else begin
            chk("wreq_pass", 32'(m_wreq), 32'(s_wreq));
            chk("wdat_pass", 32'(m_wdat), 32'(s_wdat));
            chk("rval_pass", 32'(s_rval), 32'(m_rval));
            if (m_rval) chk("rdat_pass", 32'(s_rdat), 32'(m_rdat));
            if (!s_wreq) chk("rreq_pass", 32'(m_rreq), 32'(s_rreq));
            if (s_wreq) chk("wr_stall", 32'(s_busy), 32'(m_busy));
            if (s_rreq && !s_wreq)
                chk("rd_accept", 32'(!s_busy), 32'(m_rreq && !m_busy && exp_sb.size() == 1));
            if (s_rval) begin
                chk("rd_expected", 32'(exp_rdat.size() != 0), 32'd1);
                if (exp_rdat.size() != 0) chk("rd_data", 32'(s_rdat), 32'(exp_rdat.pop_front()));
                rd_log.push_back(s_rdat);
            end
            if (m_wreq && !m_busy) begin
                if (w_left == 0) begin
                    sb_start(1'b1);
                    w_addr = m_addr;
                    w_left = int'(m_bcnt);
                end
                slv_mem[w_addr] = m_wdat;
                w_addr = w_addr + 8'd1;
                w_left--;
            end
            if (m_rreq && !m_busy) begin
                sb_start(1'b0);
                for (int i = 0; i < int'(m_bcnt); i++) rd_pend.push_back(8'(m_addr + 8'(i)));
            end
        end
    end

    // Downstream slave: optional random stall, in-order read return.
    always @(posedge clk) begin
        #1;
        m_busy = rand_busy ? 1'($urandom_range(0, 1)) : 1'b0;
        m_rval = 1'b0;
        if (!reset) rd_pend.delete();
        if (rd_pend.size() != 0 && (!rand_busy || $urandom_range(0, 1) == 1)) begin
            m_rdat = slv_mem[rd_pend.pop_front()];
            m_rval = 1'b1;
        end
    end

    task automatic wait_acc(inout int cyc);
        bit acc;
        int b;
        b = 0;
        do begin
            @(negedge clk);
            acc = !s_busy;
            @(posedge clk);
            #1;
            cyc++;
            b++;
        end while (!acc && b < 200);
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wr_burst(input logic [7:0] addr, input int n, input logic [7:0] d0,
                            input bit gaps, input int stop_after, output int cyc);
        sb_q_t q;
        q = split(addr, n, 1'b1);
        foreach (q[k]) exp_sb.push_back(q[k]);
        cyc = 0;
        for (int i = 0; i < n && i < stop_after; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_wreq = 1'b0;
                @(posedge clk);
                #1;
                cyc++;
            end
            s_wreq = 1'b1;
            s_addr = addr;
            s_bcnt = 6'(n);
            s_wdat = 8'(d0 + 8'(i));
            wait_acc(cyc);
            ref_mem[8'(addr + 8'(i))] = 8'(d0 + 8'(i));
        end
        if (stop_after >= n) s_wreq = 1'b0;
        else s_wdat = 8'(d0 + 8'(stop_after));
    endtask

    task automatic rd_burst(input logic [7:0] addr, input int n, output int cyc);
        sb_q_t q;
        int    b;
        q = split(addr, n, 1'b0);
        foreach (q[k]) exp_sb.push_back(q[k]);
        for (int i = 0; i < n; i++) exp_rdat.push_back(ref_mem[8'(addr + 8'(i))]);
        s_rreq = 1'b1;
        s_addr = addr;
        s_bcnt = 6'(n);
        cyc = 0;
        wait_acc(cyc);
        s_rreq = 1'b0;
        b = 0;
        while ((exp_rdat.size() != 0 || rd_pend.size() != 0) && b < 500) begin
            @(posedge clk);
            #1;
            b++;
        end
        chk("rd_drain", 32'(exp_rdat.size()), 32'd0);
    endtask

    task automatic clr_log();
        obs_addr.delete();
        obs_bcnt.delete();
        rd_log.delete();
    endtask

    task automatic chk_sb(input string nm, input int k, input logic [7:0] a, input int b);
        chk(nm, 32'(obs_addr[k]), 32'(a));
        chk(nm, 32'(obs_bcnt[k]), 32'(b));
    endtask

    initial begin
        sb_q_t pin;
        int    cyc;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'(i) ^ 8'h5A;
            slv_mem[i] = 8'(i) ^ 8'h5A;
        end

        // Pin the reference split itself.
        pin = split(8'hF8, 20, 1'b1);
        chk("model_n", 32'(pin.size()), 32'd3);
        chk("model_a1", 32'(pin[1].addr), 32'h00);
        chk("model_b2", 32'(pin[2].bcnt), 32'd4);

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Long write across the address wrap, then readback.
        clr_log();
        wr_burst(8'hF8, 20, 8'd0, 1'b0, 99, cyc);
        chk("w20_cycles", 32'(cyc), 32'd20);
        chk("w20_nsb", 32'(obs_addr.size()), 32'd3);
        chk_sb("w20_sb0", 0, 8'hF8, 8);
        chk_sb("w20_sb1", 1, 8'h00, 8);
        chk_sb("w20_sb2", 2, 8'h08, 4);
        clr_log();
        rd_burst(8'hF8, 20, cyc);
        chk("rb20_cycles", 32'(cyc), 32'd3);
        chk("rb20_count", 32'(rd_log.size()), 32'd20);
        for (int i = 0; i < 20; i++) chk("rb20_data", 32'(rd_log[i]), 32'(i));

        // Long read in the middle of memory.
        clr_log();
        rd_burst(8'h10, 20, cyc);
        chk("r20_cycles", 32'(cyc), 32'd3);
        chk_sb("r20_sb0", 0, 8'h10, 8);
        chk_sb("r20_sb1", 1, 8'h18, 8);
        chk_sb("r20_sb2", 2, 8'h20, 4);
        chk("r20_count", 32'(rd_log.size()), 32'd20);

        // Short bursts: passthrough with no added latency.
        clr_log();
        wr_burst(8'h30, 5, 8'd50, 1'b0, 99, cyc);
        chk("w5_cycles", 32'(cyc), 32'd5);
        rd_burst(8'h30, 5, cyc);
        chk("r5_cycles", 32'(cyc), 32'd1);
        chk_sb("w5_sb", 0, 8'h30, 5);
        chk_sb("r5_sb", 1, 8'h30, 5);

        // Exactly MAXB and MAXB+1.
        clr_log();
        wr_burst(8'h50, 8, 8'd70, 1'b0, 99, cyc);
        rd_burst(8'h50, 8, cyc);
        chk("r8_cycles", 32'(cyc), 32'd1);
        wr_burst(8'h60, 9, 8'd90, 1'b0, 99, cyc);
        rd_burst(8'h60, 9, cyc);
        chk("r9_cycles", 32'(cyc), 32'd2);
        chk("b89_nsb", 32'(obs_addr.size()), 32'd6);
        chk_sb("w9_sb1", 3, 8'h68, 1);
        chk_sb("r9_sb0", 4, 8'h60, 8);
        chk_sb("r9_sb1", 5, 8'h68, 1);

        // Random downstream stalls and upstream write gaps.
        rand_busy = 1'b1;
        wr_burst(8'hF8, 20, 8'd100, 1'b1, 99, cyc);
        rd_burst(8'hF8, 20, cyc);
        rd_burst(8'h10, 20, cyc);
        rand_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rand_sb_left", 32'(exp_sb.size()), 32'd0);

        // Reset after 10 of 20 write beats.
        wr_burst(8'h80, 20, 8'd150, 1'b0, 10, cyc);
        reset = 1'b0;
        #1;
        chk("abort_s_busy", 32'(s_busy), 32'd1);
        chk("abort_m_wreq", 32'(m_wreq), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        s_wreq = 1'b0;
        exp_sb.delete();
        reset = 1'b1;
        @(posedge clk);
        #1;
        clr_log();
        wr_burst(8'h40, 3, 8'd200, 1'b0, 99, cyc);
        chk("post_nsb", 32'(obs_addr.size()), 32'd1);
        chk_sb("post_sb", 0, 8'h40, 3);
        clr_log();
        rd_burst(8'h40, 4, cyc);
        chk("post_d0", 32'(rd_log[0]), 32'd200);
        chk("post_d3", 32'(rd_log[3]), 32'(8'h43 ^ 8'h5A));
        rd_burst(8'h80, 12, cyc);
        chk("abort_d9", 32'(rd_log[13]), 32'd159);
        chk("abort_d10", 32'(rd_log[14]), 32'(8'h8A ^ 8'h5A));

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
